// File: rtl/lbp_pkg.sv
// lbp_pkg: shared widths, image geometry and host FSM state encoding
package lbp_pkg;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 8;
  localparam int IMG_DIM = 64;
  localparam int PIX_LAST = 4095;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DUMP} host_state_t;
endpackage

// File: rtl/lbp_sp_ram.sv
// lbp_sp_ram: single-port synchronous RAM, 1-cycle registered read held when re=0
module lbp_sp_ram
  import lbp_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  // storage array, never reset
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  // read register, held between reads
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[addr];
endmodule

// File: rtl/lbp_mem_host.sv
// lbp_mem_host: grey image loader, LBP engine memory server and result streamer (optional err via LBP_MEM_HOST_ERRCHK_EN)
module lbp_mem_host
  import lbp_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              enable,
  input  logic [ADDR_W-1:0] gray_addr,
  input  logic              gray_OE,
  output logic [DATA_W-1:0] gray_data,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic              lbp_WEN,
  input  logic [DATA_W-1:0] lbp_data,
  input  logic              finish,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              done
`ifdef LBP_MEM_HOST_ERRCHK_EN
  , output logic            err
`endif
);
  host_state_t state;
  logic [ADDR_W-1:0] ld_cnt, rd_cnt;
  logic [DATA_W-1:0] lbp_q;
  logic rd_all, pf_valid, pf_last;
  logic in_hs, out_hs, load_out, issue;
  assign in_hs = state == LOAD && in_valid;
  assign out_hs = out_valid && out_ready;
  // the RAM read register acts as the one-entry prefetch buffer
  assign load_out = state == DUMP && pf_valid && (!out_valid || out_ready);
  assign issue = state == DUMP && !rd_all && (!pf_valid || load_out);
  lbp_sp_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_grey (
    .clk(clk), .rst(rst), .we(in_hs), .re(gray_OE),
    .addr(state == LOAD ? ld_cnt : gray_addr), .wdata(in_data), .rdata(gray_data)
  );
  lbp_sp_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_lbp (
    .clk(clk), .rst(rst), .we(state == RUN && lbp_WEN), .re(issue),
    .addr(state == DUMP ? rd_cnt : lbp_addr), .wdata(lbp_data), .rdata(lbp_q)
  );
  // host FSM: load, serve the engine, then stream results out
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ld_cnt <= '0;
      rd_cnt <= '0;
      rd_all <= 1'b0;
      pf_valid <= 1'b0;
      pf_last <= 1'b0;
      in_ready <= 1'b0;
      enable <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          state <= LOAD;
          in_ready <= 1'b1;
        end
        LOAD: if (in_valid) begin
          ld_cnt <= ld_cnt + ADDR_W'(1);
          if (ld_cnt == '1) begin
            state <= RUN;
            in_ready <= 1'b0;
            enable <= 1'b1;
          end
        end
        RUN: if (finish) begin
          state <= DUMP;
          enable <= 1'b0;
        end
        DUMP: begin
          if (issue) begin
            rd_cnt <= rd_cnt + ADDR_W'(rd_cnt != '1);
            rd_all <= rd_cnt == '1;
            pf_last <= rd_cnt == '1;
            pf_valid <= 1'b1;
          end else if (load_out) pf_valid <= 1'b0;
          if (load_out) begin
            out_valid <= 1'b1;
            out_data <= lbp_q;
            out_last <= pf_last;
          end else if (out_hs) out_valid <= 1'b0;
          if (out_hs && out_last) begin
            state <= IDLE;
            out_valid <= 1'b0;
            out_last <= 1'b0;
            done <= 1'b1;
            rd_cnt <= '0;
            rd_all <= 1'b0;
            pf_valid <= 1'b0;
            pf_last <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
`ifdef LBP_MEM_HOST_ERRCHK_EN
  logic [ADDR_W:0] wr_cnt;
  // sticky protocol error: stray writes, read/write collision, early finish
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_cnt <= '0;
      err <= 1'b0;
    end else begin
      wr_cnt <= state != RUN ? '0 : wr_cnt + (ADDR_W+1)'(lbp_WEN && !wr_cnt[ADDR_W]);
      if ((lbp_WEN && state != RUN) || (gray_OE && lbp_WEN) ||
          (state == RUN && finish && wr_cnt + (ADDR_W+1)'(lbp_WEN) < (ADDR_W+1)'(2**ADDR_W)))
        err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_lbp_mem_host.sv
// tb_lbp_mem_host: randomized self-checking bench for lbp_mem_host against array reference model
module tb_lbp_mem_host;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, enable, gray_OE = 1'b0, lbp_WEN = 1'b0, finish = 1'b0;
  logic out_valid, out_last, out_ready = 1'b0, done;
  logic [7:0] in_data = '0, gray_data, lbp_data = '0, out_data;
  logic [11:0] gray_addr = '0, lbp_addr = '0;
`ifdef LBP_MEM_HOST_ERRCHK_EN
  logic err;
`endif
  logic [7:0] grey_m [4096];
  logic [7:0] lbp_m [4096];
  int errors = 0, checks = 0;

  lbp_mem_host dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .enable(enable), .gray_addr(gray_addr), .gray_OE(gray_OE), .gray_data(gray_data),
    .lbp_addr(lbp_addr), .lbp_WEN(lbp_WEN), .lbp_data(lbp_data), .finish(finish),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .done(done)
`ifdef LBP_MEM_HOST_ERRCHK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input bit toggle, input bit ramp, input logic [7:0] key);
    int n = 0, cyc = 0;
    while (n < 4096 && cyc < 20000) begin
      in_valid = !toggle || (cyc % 2 == 0);
      in_data = ramp ? (8'(n) ^ key) : (n == 4095 ? 8'hFF : 8'($urandom));
      if (in_valid && in_ready) begin
        grey_m[n] = in_data;
        n++;
      end
      tick;
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (n !== 4096) begin errors++; $display("FAIL load_count: got %0d want 4096", n); end
    checks++;
    if (in_ready !== 1'b0 || enable !== 1'b1) begin
      errors++; $display("FAIL load_end: in_ready=%b enable=%b want 0/1", in_ready, enable);
    end
  endtask

  task automatic gray_rd(input int a);
    gray_addr = 12'(a);
    gray_OE = 1'b1;
    tick;
    gray_OE = 1'b0;
    gray_addr = 12'($urandom);
    checks++;
    if (gray_data !== grey_m[a]) begin errors++; $display("FAIL gray_rd[%0d]: got %h want %h", a, gray_data, grey_m[a]); end
    tick;
    checks++;
    if (gray_data !== grey_m[a]) begin errors++; $display("FAIL gray_hold[%0d]: got %h want %h", a, gray_data, grey_m[a]); end
  endtask

  task automatic do_finish(input int a, input logic [7:0] d);
    lbp_WEN = 1'b1; lbp_addr = 12'(a); lbp_data = d; lbp_m[a] = d;
    finish = 1'b1;
    out_ready = 1'b0;
    tick;
    lbp_WEN = 1'b0; finish = 1'b0;
    checks++;
    if (enable !== 1'b0) begin errors++; $display("FAIL enable_drop: got %b want 0", enable); end
    tick;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL dump_lat1: out_valid=%b want 0", out_valid); end
    tick;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL dump_lat2: out_valid=%b want 1", out_valid); end
  endtask

  task automatic do_dump(input int stall_at, input int rst_at);
    int idx = 0, cyc = 0, bad = 0, lastbad = 0, stallbad = 0, stall_n = 0, dn = 0;
    int first_bad = -1;
    bit did_rst = 0;
    while (idx < 4096 && cyc < 30000) begin
      if (out_valid && idx == rst_at) begin
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || enable !== 1'b0) begin
          errors++; $display("FAIL async_rst: out_valid=%b enable=%b want 0/0", out_valid, enable);
        end
        did_rst = 1;
        break;
      end
      if (out_valid && idx == stall_at && stall_n < 5) begin
        out_ready = 1'b0;
        stall_n++;
        if (out_data !== lbp_m[idx]) stallbad++;
      end else out_ready = ($urandom % 4) != 0;
      if (out_valid && out_ready) begin
        if (out_data !== lbp_m[idx]) begin bad++; if (first_bad < 0) first_bad = idx; end
        if (out_last !== (idx == 4095)) lastbad++;
        idx++;
      end
      if (done) dn++;
      tick;
      cyc++;
    end
    out_ready = 1'b0;
    if (did_rst) begin
      repeat (2) tick;
      rst = 1'b0;
    end else begin
      checks++;
      if (bad != 0 || idx != 4096) begin
        errors++; $display("FAIL dump_data: %0d bad bytes (first %0d), %0d transferred, want 0 bad and 4096", bad, first_bad, idx);
      end
      checks++;
      if (lastbad != 0) begin errors++; $display("FAIL dump_last: %0d misplaced out_last, want 0", lastbad); end
      if (stall_at >= 0) begin
        checks++;
        if (stallbad != 0 || stall_n != 5) begin
          errors++; $display("FAIL dump_stall: %0d unstable cycles over %0d stalls, want 0 over 5", stallbad, stall_n);
        end
      end
      checks++;
      if (done !== 1'b1 || dn != 0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL done_pulse: done=%b early=%0d out_valid=%b in_ready=%b want 1/0/0/0", done, dn, out_valid, in_ready);
      end
      tick;
      checks++;
      if (done !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL rearm: done=%b in_ready=%b want 0/1", done, in_ready);
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) tick;
    checks++;
    if ({in_ready, enable, out_valid, out_last, done, gray_data, out_data} !== 21'd0) begin
      errors++; $display("FAIL reset_state: got %b want all zero", {in_ready, enable, out_valid, out_last, done, gray_data, out_data});
    end
`ifdef LBP_MEM_HOST_ERRCHK_EN
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
`endif
    rst = 1'b0;
    tick;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_rearm: in_ready=%b want 1", in_ready); end
  endtask

  task automatic test_load_ramp;
    do_load(0, 1, 8'h00);
    in_valid = 1'b1; in_data = 8'hEE;
    tick;
    in_valid = 1'b0;
    gray_rd(130);
    checks++;
    if (gray_data !== 8'h82) begin errors++; $display("FAIL gray_130: got %h want 82", gray_data); end
    gray_rd(0);
    for (int i = 0; i < 4; i++) gray_rd(int'($urandom_range(0, 4095)));
  endtask

  task automatic test_run_full;
    for (int a = 0; a < 4096; a++) begin
      lbp_WEN = 1'b1; lbp_addr = 12'(a); lbp_data = 8'($urandom); lbp_m[a] = lbp_data;
      tick;
    end
    lbp_WEN = 1'b1; lbp_addr = 12'd65; lbp_data = 8'hA5; lbp_m[65] = 8'hA5;
    tick;
    do_finish(4030, 8'h3C);
    do_dump(10, -1);
`ifdef LBP_MEM_HOST_ERRCHK_EN
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_clean: got %b want 0", err); end
`endif
  endtask

  task automatic test_ignored_inputs;
    tick;
    lbp_WEN = 1'b1; lbp_addr = 12'd0; lbp_data = ~lbp_m[0];
    finish = 1'b1;
    tick;
    lbp_WEN = 1'b0; finish = 1'b0;
    tick;
    checks++;
    if (in_ready !== 1'b1 || enable !== 1'b0) begin
      errors++; $display("FAIL ignore_state: in_ready=%b enable=%b want 1/0", in_ready, enable);
    end
`ifdef LBP_MEM_HOST_ERRCHK_EN
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_stray: got %b want 1", err); end
`endif
  endtask

  task automatic test_load_toggle;
    do_load(1, 0, 8'h00);
    gray_rd(4095);
    checks++;
    if (gray_data !== 8'hFF) begin errors++; $display("FAIL gray_4095: got %h want ff", gray_data); end
    for (int i = 0; i < 3; i++) gray_rd(int'($urandom_range(0, 4095)));
  endtask

  task automatic test_run_short_reset;
    for (int i = 0; i < 20; i++) begin
      int a = int'($urandom_range(1, 4095));
      lbp_WEN = 1'b1; lbp_addr = 12'(a); lbp_data = 8'($urandom); lbp_m[a] = lbp_data;
      tick;
    end
    do_finish(65, 8'h5B);
    do_dump(-1, 2000);
    for (int i = 0; i < 5 && in_ready !== 1'b1; i++) tick;
    checks++;
    if (in_ready !== 1'b1 || enable !== 1'b0) begin
      errors++; $display("FAIL post_rst: in_ready=%b enable=%b want 1/0", in_ready, enable);
    end
    do_load(0, 1, 8'h5A);
    gray_rd(0);
    gray_rd(4095);
  endtask

  initial begin
    test_reset;
    test_load_ramp;
    test_run_full;
    test_ignored_inputs;
    test_load_toggle;
    test_run_short_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
